// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - loader byte stream, fetch port and status bundle for imem_loader
interface imem_loader_if;
    logic        ld_start;
    logic [6:0]  ld_len;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic [31:0] a;
    logic [31:0] rd;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output ld_start, ld_len, ld_valid, ld_data, a,
        input  ld_ready, rd, busy, done, err
    );

    modport slave (
        input  ld_start, ld_len, ld_valid, ld_data, a,
        output ld_ready, rd, busy, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - instruction memory filled from a little-endian byte stream, combinational fetch port
module imem_loader #(
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] word_ptr;
    logic [AW-1:0] last_ptr;
    logic [1:0]    byte_cnt;
    logic [23:0]   partial;
    logic          err_q;
    logic          ready_c, busy_c, done_c;
    logic          len_ok, accept, word_we;

    // Contents start at zero and deliberately survive reset.
    logic [31:0]   mem [DEPTH] = '{default: '0};

    assign len_ok  = (bus.ld_len != 7'd0) && (int'(bus.ld_len) <= DEPTH);
    assign accept  = (state_q == LOAD) && bus.ld_valid;
    assign word_we = accept && (byte_cnt == 2'd3);

    always_comb begin
        state_d = state_q;
        ready_c = 1'b0;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ld_start && len_ok) state_d = LOAD;
            end
            LOAD: begin
                ready_c = 1'b1;
                busy_c  = 1'b1;
                if (word_we && (word_ptr == last_ptr)) state_d = DONE;
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            word_ptr <= '0;
            last_ptr <= '0;
            byte_cnt <= 2'd0;
            partial  <= 24'd0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && bus.ld_start) begin
                if (len_ok) begin
                    last_ptr <= AW'(bus.ld_len - 7'd1);
                    word_ptr <= '0;
                    byte_cnt <= 2'd0;
                    partial  <= 24'd0;
                    err_q    <= 1'b0;
                end else begin
                    err_q    <= 1'b1;
                end
            end
            if (accept) begin
                case (byte_cnt)
                    2'd0:    partial[7:0]   <= bus.ld_data;
                    2'd1:    partial[15:8]  <= bus.ld_data;
                    2'd2:    partial[23:16] <= bus.ld_data;
                    default: partial        <= 24'd0;
                endcase
                byte_cnt <= byte_cnt + 2'd1;
                if (word_we) word_ptr <= word_ptr + 1'b1;
            end
        end
    end

    // Byte 3 is taken straight from the bus so the word lands on the accepting edge.
    always_ff @(posedge clk) begin
        if (word_we) mem[word_ptr] <= {bus.ld_data, partial};
    end

    assign bus.rd       = mem[bus.a[AW+1:2]];
    assign bus.ld_ready = ready_c;
    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.err      = err_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.a[31:AW+2], bus.a[1:0]};
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of 32-bit instruction words, a power of two from 2 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset; it is asynchronous and active-high.
REQ-004 The block SHALL have port ld_start, input, 1 bit, a one-cycle request to begin a load.
REQ-005 The block SHALL have port ld_len, input, 7 bits, the number of words to load, sampled with ld_start.
REQ-006 The block SHALL have port ld_valid, input, 1 bit, meaning the loader byte on ld_data is valid.
REQ-007 The block SHALL have port ld_data, input, 8 bits, the loader byte stream.
REQ-008 The block SHALL have port ld_ready, output, 1 bit, meaning the block accepts a byte this cycle.
REQ-009 The block SHALL have port a, input, 32 bits, the fetch byte address.
REQ-010 The block SHALL have port rd, output, 32 bits, the fetched instruction word.
REQ-011 The block SHALL have port busy, output, 1 bit, meaning a load is in progress.
REQ-012 The block SHALL have port done, output, 1 bit, a one-cycle pulse on load completion.
REQ-013 The block SHALL have port err, output, 1 bit, a sticky flag for an illegal ld_len.

Function
REQ-014 The block SHALL implement states IDLE, LOAD and DONE.
REQ-015 In IDLE: ld_ready=0 and busy=0; incoming bytes are ignored.
REQ-016 In IDLE with ld_start=1 and 1<=ld_len<=DEPTH, the block SHALL latch ld_len, clear word_ptr and byte_cnt, clear err, and enter LOAD next cycle.
REQ-017 In IDLE with ld_start=1 and ld_len=0 or ld_len>DEPTH, the block SHALL set err=1, stay in IDLE, and leave memory unchanged.
REQ-018 In LOAD: ld_ready=1 and busy=1; a byte is accepted only when ld_valid and ld_ready are both 1 on a clock edge.
REQ-019 Byte assembly SHALL be little-endian: accepted byte k (k=0..3) of a word goes to bits [8k+7:8k].
REQ-020 On the edge accepting byte 3, the assembled word SHALL be written to mem[word_ptr], word_ptr SHALL increment, and byte_cnt SHALL wrap to 0.
REQ-021 If that write is to word_ptr = latched_len-1, the next state SHALL be DONE; accepted bytes never exceed 4*latched_len.
REQ-022 ld_start SHALL be ignored in LOAD and DONE.
REQ-023 DONE SHALL last exactly one cycle with done=1, busy=0 and ld_ready=0, then return to IDLE.
REQ-024 The read port SHALL be combinational: rd = mem[a[log2(DEPTH)+1:2]], with a[1:0] and the upper bits ignored.
REQ-025 A read of the word being written on the same edge SHALL return the old contents until after that edge.
REQ-026 Memory contents SHALL initialise to 0 at simulation start and are not reset.

Reset
REQ-027 While rst=1 the block SHALL be in IDLE with ld_ready=0, busy=0, done=0, err=0, word_ptr=0, byte_cnt=0 and the partial word cleared.
REQ-028 rst asserted mid-LOAD SHALL discard the partial word, return to IDLE immediately, and keep already-written words intact.
REQ-029 rd SHALL remain valid during and after reset.

Verification
REQ-030 Load ld_len=2 with bytes 13,00,50,00,B3,00,00,00 -> mem[0]=32'h00500013, mem[1]=32'h000000B3, done pulses once, busy high for exactly 8 accepted-byte cycles plus stall cycles.
REQ-031 Same load with ld_valid deasserted every other cycle -> identical memory contents, no extra writes, ld_ready held at 1 throughout LOAD.
REQ-032 ld_start with ld_len=0, then ld_len=65 (DEPTH=64) -> err=1 each time, state stays IDLE, memory unchanged; then a legal start -> err=0.
REQ-033 rst after 6 bytes of a 2-word load -> mem[0] written, mem[1] unchanged, IDLE with ld_ready=0; a new load then starts at word 0.
REQ-034 Full load ld_len=64, word i=i -> a=32'h000000FC gives rd=63; a=32'h00000103 aliases to word 0 and gives rd=0; ld_start pulsed mid-load has no effect.
